// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 RS232 receive front-end with a one-entry holding register.
// The RXD input is synchronized and framed. The byte is then offered to the
// consumer through Data/Empty with a Data_read pop strobe. Framing errors
// pulse Frame_err, and a lost byte sets the sticky Overrun flag.
module rs232_rx #(
    parameter int BAUD_DIV = 174
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       RXD,
    output logic [7:0] Data,
    output logic       Empty,
    input  logic       Data_read,
    output logic       Frame_err,
    output logic       Overrun
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rxd_m;
    logic          rxd_s;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          cnt_half;
    logic          cnt_full;
    logic          stop_edge;
    logic          deliver;
    logic          bad_stop;

    // Two-flop synchronizer for RXD.
    // sync_fill marks when rxd_s reflects the real line after a reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxd_m     <= 1'b1;
            rxd_s     <= 1'b1;
            sync_fill <= '0;
        end else begin
            rxd_m     <= RXD;
            rxd_s     <= rxd_m;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Bit-timing decodes and stop-bit outcome for the current cycle.
    always_comb begin
        cnt_half  = (cnt == HALF_LAST);
        cnt_full  = (cnt == FULL_LAST);
        stop_edge = (state == S_STOP) && cnt_full;
        deliver   = stop_edge && rxd_s;
        bad_stop  = stop_edge && !rxd_s;
    end

    // Deframing FSM.
    // 'armed' blocks a start until the line has been seen high. This covers
    // both the case after a framing error and the case after reset, where the
    // synchronizer's reset value of 1 is not trusted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!armed) begin
                        if (sync_fill[1] && rxd_s)
                            armed <= 1'b1;
                    end else if (!rxd_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_half) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_full) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_full) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        armed <= rxd_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Holding register, read handshake, Frame_err pulse and sticky Overrun.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Data      <= '0;
            Empty     <= 1'b1;
            Overrun   <= 1'b0;
            Frame_err <= 1'b0;
        end else begin
            Frame_err <= bad_stop;
            if (deliver) begin
                if (Empty) begin
                    Data  <= shreg;
                    Empty <= 1'b0;
                end else if (Data_read) begin
                    Data    <= shreg;
                    Overrun <= 1'b0;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Data_read && !Empty) begin
                Empty   <= 1'b1;
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// Testbench for rs232_rx with BAUD_DIV=8.
// Directed scenarios are followed by a randomized frame stream. The random
// stream is checked against a transaction-level model of the holding register.
module tb_rs232_rx;

    localparam int BAUD = 8;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       empty;
    logic       data_read;
    logic       frame_err;
    logic       overrun;

    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned fe_cnt;

    rs232_rx #(.BAUD_DIV(BAUD)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .RXD       (rxd),
        .Data      (data),
        .Empty     (empty),
        .Data_read (data_read),
        .Frame_err (frame_err),
        .Overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts high cycles of Frame_err, so a one-cycle pulse adds exactly 1.
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the edge where cyc == c.
    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        wait_cycles(BAUD);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        wait_cycles(1);
        data_read = 1'b0;
    endtask

    int unsigned p0;
    logic [7:0]  m_data;
    logic        m_empty;
    logic        m_ov;
    int unsigned m_fe;
    logic        prev_bad;

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_err     = 0;
        fe_cnt    = 0;
        rst_n     = 1'b0;
        rxd       = 1'b1;
        data_read = 1'b0;

        // Reset state
        wait_cycles(4);
        check("rst_data", data, 8'h00);
        check("rst_empty", empty, 1);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        wait_cycles(20);

        // A5: exact delivery edge is E0+4+72, where E0 = start edge + 3
        p0 = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_until(p0 + 78);
                check("a5_empty_before", empty, 1);
                wait_until(p0 + 79);
                check("a5_empty", empty, 0);
                check("a5_data", data, 8'hA5);
            end
        join
        pulse_read();
        check("a5_read_empty", empty, 1);
        check("a5_read_data_held", data, 8'hA5);
        wait_cycles(10);

        // Back-to-back bytes with no read produce an overrun
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        check("ovr_data", data, 8'h3C);
        check("ovr_flag", overrun, 1);
        check("ovr_empty", empty, 0);
        pulse_read();
        check("ovr_clr_flag", overrun, 0);
        check("ovr_clr_empty", empty, 1);
        wait_cycles(10);

        // Bad stop bit gives a single Frame_err cycle; the byte is discarded
        send_frame(8'h55, 1'b0);
        rxd = 1'b1;
        wait_cycles(16);
        check("fe_count", fe_cnt, 1);
        check("fe_empty", empty, 1);
        check("fe_data_kept", data, 8'h3C);
        send_frame(8'h12, 1'b1);
        check("fe_next_data", data, 8'h12);
        check("fe_next_empty", empty, 0);
        pulse_read();
        wait_cycles(10);

        // A 2-cycle glitch is a false start
        rxd = 1'b0;
        wait_cycles(2);
        rxd = 1'b1;
        wait_cycles(16);
        check("glitch_empty", empty, 1);
        check("glitch_fe", fe_cnt, 1);
        send_frame(8'h81, 1'b1);
        check("glitch_next_data", data, 8'h81);
        check("glitch_next_empty", empty, 0);
        pulse_read();
        wait_cycles(10);

        // Read on the exact stop-sample edge of the second byte
        p0 = cyc;
        fork
            begin
                send_frame(8'h5A, 1'b1);
                send_frame(8'hE7, 1'b1);
            end
            begin
                wait_until(p0 + 79);
                check("rdedge_first", data, 8'h5A);
                wait_until(p0 + 80 + 78);
                data_read = 1'b1;
                wait_until(p0 + 80 + 79);
                data_read = 1'b0;
                check("rdedge_data", data, 8'hE7);
                check("rdedge_empty", empty, 0);
                check("rdedge_overrun", overrun, 0);
            end
        join
        pulse_read();
        check("rdedge_final_empty", empty, 1);
        wait_cycles(10);

        // Reset during data bit 4 of FF, then the line is held low after release
        rxd = 1'b0;
        wait_cycles(BAUD);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b1;
        wait_cycles(3);
        rst_n = 1'b0;
        rxd   = 1'b0;
        wait_cycles(2);
        check("midrst_data", data, 8'h00);
        check("midrst_empty", empty, 1);
        check("midrst_overrun", overrun, 0);
        check("midrst_fe", frame_err, 0);
        rst_n = 1'b1;
        wait_cycles(40);
        rxd = 1'b1;
        wait_cycles(50);
        check("midrst_low_ignored", empty, 1);
        send_frame(8'h0F, 1'b1);
        check("midrst_next_data", data, 8'h0F);
        check("midrst_next_empty", empty, 0);
        check("midrst_next_overrun", overrun, 0);
        check("midrst_next_fe", fe_cnt, 1);

        // Randomized frame stream against the holding-register model
        m_data   = 8'h0F;
        m_empty  = 1'b0;
        m_ov     = 1'b0;
        m_fe     = 1;
        prev_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            logic       good;
            int         gap;
            b    = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            gap  = prev_bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            rxd  = 1'b1;
            if (gap > 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    pulse_read();
                    if (!m_empty) begin
                        m_empty = 1'b1;
                        m_ov    = 1'b0;
                    end
                    wait_cycles(gap * BAUD - 1);
                end else begin
                    wait_cycles(gap * BAUD);
                end
            end
            send_frame(b, good);
            rxd = 1'b1;
            if (good) begin
                if (m_empty) begin
                    m_data  = b;
                    m_empty = 1'b0;
                end else begin
                    m_ov = 1'b1;
                end
            end else begin
                m_fe++;
            end
            prev_bad = !good;
            check($sformatf("rnd%0d_data", i), data, m_data);
            check($sformatf("rnd%0d_empty", i), empty, m_empty);
            check($sformatf("rnd%0d_overrun", i), overrun, m_ov);
            check($sformatf("rnd%0d_fe", i), fe_cnt, m_fe);
        end

        // A read on an empty register is ignored and leaves Overrun alone
        wait_cycles(16);
        pulse_read();
        if (!m_empty) begin
            m_empty = 1'b1;
            m_ov    = 1'b0;
        end
        pulse_read();
        check("final_empty", empty, m_empty);
        check("final_overrun", overrun, m_ov);
        check("final_data", data, m_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
